// File: rtl/codec_config_sequencer_if.sv
// -----------------------------------------------------------------------------
// codec_config_sequencer_if
//
// Connection between the codec configuration sequencer and the shared I2C
// write controller.
//   i2c_rst_n    active-low reset/launch to the controller (low = idle/abort)
//   i2c_address  7-bit codec device address
//   i2c_register 7-bit register field of the current table entry
//   i2c_data     9-bit data field of the current table entry
//   i2c_rw       transfer direction, always 0 (write)
//   i2c_done     controller completion flag
//   i2c_error    controller status: 0 running, 4'hF success, 1..5 fault code
//
// Modports: master = sequencer side, slave = I2C controller side.
// -----------------------------------------------------------------------------
interface codec_config_sequencer_if;
    logic       i2c_rst_n;
    logic [6:0] i2c_address;
    logic [6:0] i2c_register;
    logic [8:0] i2c_data;
    logic       i2c_rw;
    logic       i2c_done;
    logic [3:0] i2c_error;

    modport master (
        output i2c_rst_n, i2c_address, i2c_register, i2c_data, i2c_rw,
        input  i2c_done, i2c_error
    );

    modport slave (
        input  i2c_rst_n, i2c_address, i2c_register, i2c_data, i2c_rw,
        output i2c_done, i2c_error
    );
endinterface

// File: rtl/codec_config_sequencer.sv
// -----------------------------------------------------------------------------
// codec_config_sequencer
//
// Walks a fixed 11-entry table of audio-codec register writes through the
// shared I2C write controller. Each write is launched by holding the
// controller's active-low reset low for HOLD_CYCLES with the entry presented,
// then releasing it. Completion/fault status is synchronized, failed attempts
// are retried up to MAX_RETRIES attempts in total, and writes are separated by
// GAP_CYCLES idle cycles.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   start        level; starts a sequence when the FSM is IDLE, DONE or FAIL
//   bus          I2C controller connection (codec_config_sequencer_if.master)
//   busy         high from sequence start until DONE/FAIL
//   config_done  high once every table entry was written successfully
//   config_fail  high when an entry exhausted its attempts
//   fail_index   table index of the failing entry
//   fail_code    last fault code of the failing entry (4'hE = timeout)
//
// Build option:
//   AUTO_START_EN  when defined, the sequence starts by itself on the first
//                  clk edge after rst is released; later restarts need start.
// -----------------------------------------------------------------------------
module codec_config_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         GAP_CYCLES     = 1000,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter int         MAX_RETRIES    = 3,
    parameter int         HOLD_CYCLES    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    codec_config_sequencer_if.master bus,
    output logic                     busy,
    output logic                     config_done,
    output logic                     config_fail,
    output logic [3:0]               fail_index,
    output logic [3:0]               fail_code
);

    localparam logic [3:0] NUM_ENTRIES  = 4'd11;
    localparam logic [3:0] CODE_OK      = 4'hF;
    localparam logic [3:0] CODE_TIMEOUT = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_RETRY, S_GAP, S_DONE, S_FAIL
    } state_t;

    // {register[6:0], data[8:0]} for each table index.
    function automatic logic [15:0] entry(input logic [3:0] idx);
        // NOTE: a default arm keeps this combinational lookup fully specified,
        // so no latch is inferred for indices past the end of the table.
        case (idx)
            4'd0:    entry = {7'h0F, 9'h000};
            4'd1:    entry = {7'h00, 9'h017};
            4'd2:    entry = {7'h01, 9'h017};
            4'd3:    entry = {7'h02, 9'h079};
            4'd4:    entry = {7'h03, 9'h079};
            4'd5:    entry = {7'h04, 9'h012};
            4'd6:    entry = {7'h05, 9'h000};
            4'd7:    entry = {7'h06, 9'h000};
            4'd8:    entry = {7'h07, 9'h002};
            4'd9:    entry = {7'h08, 9'h000};
            4'd10:   entry = {7'h09, 9'h001};
            default: entry = 16'h0000;
        endcase
    endfunction

    state_t      state;
    logic [3:0]  index;
    logic [3:0]  retry;
    logic [3:0]  code_q;
    logic        last_ok;      // previous RUN ended in success
    logic        launch_n;     // registered i2c_rst_n
    logic [15:0] hold_cnt;
    logic [15:0] tmo_cnt;
    logic [15:0] gap_cnt;
    logic        done_s1, done_s2;
    logic [3:0]  err_s1, err_s2;
    logic        auto_go;

    logic run_fault;
    logic run_ok;

    assign bus.i2c_address                   = DEV_ADDR;
    assign bus.i2c_rw                        = 1'b0;
    assign {bus.i2c_register, bus.i2c_data}  = entry(index);
    assign bus.i2c_rst_n                     = launch_n;

    assign run_fault = (err_s2 >= 4'd1) && (err_s2 <= 4'd5);
    assign run_ok    = done_s2 && (err_s2 == CODE_OK);

`ifdef AUTO_START_EN
    // Armed by reset, consumed on the first clock edge afterwards.
    logic auto_arm;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) auto_arm <= 1'b1;
        else      auto_arm <= 1'b0;
    end
    assign auto_go = auto_arm;
`else
    assign auto_go = 1'b0;
`endif

    // Controller status comes from another clock domain's logic; only the
    // second flop is used by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the
        // two-stage synchronizer into one stage.
        if (!rst) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            err_s1  <= 4'h0;
            err_s2  <= 4'h0;
        end else begin
            done_s1 <= bus.i2c_done;
            done_s2 <= done_s1;
            err_s1  <= bus.i2c_error;
            err_s2  <= err_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            index       <= 4'd0;
            retry       <= 4'd0;
            code_q      <= 4'h0;
            last_ok     <= 1'b0;
            launch_n    <= 1'b0;
            hold_cnt    <= 16'd0;
            tmo_cnt     <= 16'd0;
            gap_cnt     <= 16'd0;
            busy        <= 1'b0;
            config_done <= 1'b0;
            config_fail <= 1'b0;
            fail_index  <= 4'd0;
            fail_code   <= 4'h0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start || auto_go) begin
                        state       <= S_LOAD;
                        index       <= 4'd0;
                        retry       <= 4'd0;
                        hold_cnt    <= 16'd0;
                        busy        <= 1'b1;
                        config_done <= 1'b0;
                        config_fail <= 1'b0;
                        fail_index  <= 4'd0;
                        fail_code   <= 4'h0;
                    end
                end

                S_LOAD: begin
                    if (hold_cnt == 16'(HOLD_CYCLES - 1)) begin
                        state    <= S_RUN;
                        launch_n <= 1'b1;
                        tmo_cnt  <= 16'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                S_RUN: begin
                    // A fault wins over a simultaneous success indication.
                    if (run_fault) begin
                        state    <= S_RETRY;
                        code_q   <= err_s2;
                        launch_n <= 1'b0;
                    end else if (run_ok) begin
                        state    <= S_GAP;
                        index    <= index + 4'd1;
                        retry    <= 4'd0;
                        last_ok  <= 1'b1;
                        gap_cnt  <= 16'd0;
                        launch_n <= 1'b0;
                    end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        state    <= S_RETRY;
                        code_q   <= CODE_TIMEOUT;
                        launch_n <= 1'b0;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                S_RETRY: begin
                    if (int'(retry) + 1 < MAX_RETRIES) begin
                        state   <= S_GAP;
                        retry   <= retry + 4'd1;
                        last_ok <= 1'b0;
                        gap_cnt <= 16'd0;
                    end else begin
                        state       <= S_FAIL;
                        busy        <= 1'b0;
                        config_fail <= 1'b1;
                        fail_index  <= index;
                        fail_code   <= code_q;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
                        if (last_ok && (index == NUM_ENTRIES)) begin
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            config_done <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            hold_cnt <= 16'd0;
                        end
                    end else if (gap_cnt != 16'hFFFF) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_codec_config_sequencer
//
// Self-checking bench for codec_config_sequencer. A behavioural I2C controller
// answers each launch from a per-scenario response table (success, fault code
// or hang). The expected launch order and final status are derived from the
// same response table by walking the configuration rules directly. A per-cycle
// process checks constant outputs, status consistency and that the entry on
// the bus during a transaction is the one the walk predicts.
// -----------------------------------------------------------------------------
module tb_codec_config_sequencer;

    localparam int GAP  = 20;
    localparam int TMO  = 500;
    localparam int HOLD = 4;
    localparam int MAXR = 3;

    localparam logic [3:0] R_OK   = 4'hF;
    localparam logic [3:0] R_HANG = 4'h0;

    localparam logic [6:0] TBL_REG [11] = '{7'h0F, 7'h00, 7'h01, 7'h02, 7'h03,
                                            7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
    localparam logic [8:0] TBL_DAT [11] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079,
                                            9'h012, 9'h000, 9'h000, 9'h002, 9'h000, 9'h001};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, config_done, config_fail;
    logic [3:0] fail_index, fail_code;

    codec_config_sequencer_if ifc ();

    codec_config_sequencer #(
        .DEV_ADDR      (7'h1A),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (MAXR),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (ifc),
        .busy       (busy),
        .config_done(config_done),
        .config_fail(config_fail),
        .fail_index (fail_index),
        .fail_code  (fail_code)
    );

    initial forever #5 clk = ~clk;

    // Scenario response table and observation log.
    logic [3:0] resp [11][MAXR];
    int         att [11];
    int         launch_idx [$];
    logic [6:0] launch_reg [$];
    logic [8:0] launch_dat [$];

    // Expectations from the walk.
    int         exp_seq [$];
    logic       exp_fail;
    logic [3:0] exp_fidx, exp_fcode;

    bit         first_launch = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_idx(input logic [6:0] r, input logic [8:0] d);
        for (int i = 0; i < 11; i++)
            if (TBL_REG[i] == r && TBL_DAT[i] == d) return i;
        return -1;
    endfunction

    function automatic int count_idx(input int v);
        int n = 0;
        foreach (launch_idx[i]) if (launch_idx[i] == v) n++;
        return n;
    endfunction

    // ---------------- behavioural I2C controller + launch recorder ----------
    initial begin
        bit         was_high = 1'b0;
        bit         last_ok = 1'b0;
        int         low_len = 0;
        int         high_len = 0;
        int         lat = 0;
        int         cnt = 0;
        logic [3:0] cur_resp = R_OK;
        ifc.i2c_done  = 1'b0;
        ifc.i2c_error = 4'h0;
        forever begin
            @(negedge clk);
            if (ifc.i2c_rst_n !== 1'b1) begin
                if (was_high) begin
                    last_ok = (cur_resp == R_OK);
                    if (cur_resp == R_HANG && rst) check("timeout_len", high_len, TMO);
                    was_high = 1'b0;
                    low_len  = 0;
                end
                low_len++;
                ifc.i2c_done  = 1'b0;
                ifc.i2c_error = 4'h0;
            end else begin
                if (!was_high) begin
                    int idx, a;
                    idx = find_idx(ifc.i2c_register, ifc.i2c_data);
                    check("launch_entry_valid", (idx >= 0), 1);
                    if (idx < 0) idx = 0;
                    launch_idx.push_back(idx);
                    launch_reg.push_back(ifc.i2c_register);
                    launch_dat.push_back(ifc.i2c_data);
                    if (!first_launch)
                        check("gap_len", low_len, last_ok ? GAP + HOLD : GAP + HOLD + 1);
                    first_launch = 1'b0;
                    a = att[idx];
                    att[idx]++;
                    cur_resp = resp[idx][(a < MAXR) ? a : MAXR - 1];
                    lat      = $urandom_range(3, 150);
                    cnt      = 0;
                    high_len = 0;
                    was_high = 1'b1;
                end
                high_len++;
                cnt++;
                if (cnt == lat && cur_resp != R_HANG) begin
                    ifc.i2c_error = cur_resp;
                    ifc.i2c_done  = (cur_resp == R_OK) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // ---------------- per-cycle compare against the walk ---------------------
    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            bit ok;
            int n;
            ok = (ifc.i2c_address == 7'h1A) && (ifc.i2c_rw == 1'b0)
                 && !(config_done && config_fail)
                 && !(busy && (config_done || config_fail));
            if (ifc.i2c_rst_n === 1'b1) begin
                n  = launch_idx.size();
                ok = ok && busy && (n > 0) && (n <= exp_seq.size());
                if (ok)
                    ok = (ifc.i2c_register == TBL_REG[exp_seq[n-1]])
                         && (ifc.i2c_data == TBL_DAT[exp_seq[n-1]]);
            end
            check("cycle_outputs", ok, 1);
        end
    end

    // ---------------- helpers -----------------------------------------------
    task automatic fill_ok();
        for (int i = 0; i < 11; i++)
            for (int a = 0; a < MAXR; a++) resp[i][a] = R_OK;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 11; i++)
            for (int a = 0; a < MAXR; a++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r < 9)       resp[i][a] = R_OK;
                else if (r < 15) resp[i][a] = 4'($urandom_range(1, 5));
                else             resp[i][a] = R_HANG;
            end
    endtask

    // Walk the table: each entry gets up to MAXR attempts; a success moves on,
    // exhausting attempts stops the sequence with that entry's last code.
    task automatic build_exp();
        bit stop = 1'b0;
        exp_seq.delete();
        exp_fail  = 1'b0;
        exp_fidx  = 4'd0;
        exp_fcode = 4'h0;
        for (int i = 0; i < 11 && !stop; i++) begin
            for (int a = 0; a < MAXR; a++) begin
                exp_seq.push_back(i);
                if (resp[i][a] == R_OK) break;
                if (a == MAXR - 1) begin
                    exp_fail  = 1'b1;
                    exp_fidx  = 4'(i);
                    exp_fcode = (resp[i][a] == R_HANG) ? 4'hE : resp[i][a];
                    stop      = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_log();
        launch_idx.delete();
        launch_reg.delete();
        launch_dat.delete();
        for (int i = 0; i < 11; i++) att[i] = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        bit ended = 1'b0;
        for (int c = 0; c < 30000 && !ended; c++) begin
            @(negedge clk);
            #2;
            if (!busy && (config_done || config_fail)) ended = 1'b1;
        end
        check({name, "_finished"}, ended, 1);
    endtask

    task automatic check_result(input string name);
        int n;
        check({name, "_launches"}, launch_idx.size(), exp_seq.size());
        n = (launch_idx.size() < exp_seq.size()) ? launch_idx.size() : exp_seq.size();
        for (int i = 0; i < n; i++)
            check({name, "_launch_order"}, launch_idx[i], exp_seq[i]);
        check({name, "_config_done"}, config_done, !exp_fail);
        check({name, "_config_fail"}, config_fail, exp_fail);
        check({name, "_fail_index"}, fail_index, exp_fidx);
        check({name, "_fail_code"}, fail_code, exp_fcode);
        check({name, "_busy"}, busy, 0);
        check({name, "_i2c_rst_n"}, ifc.i2c_rst_n, 0);
    endtask

    task automatic run(input string name, input bit poke_busy);
        clear_log();
        build_exp();
        first_launch = 1'b1;
        pulse_start();
        if (poke_busy) begin
            repeat ($urandom_range(10, 600)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_end(name);
        check_result(name);
    endtask

    // ---------------- watchdog ----------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        fill_ok();
        build_exp();
        repeat (3) @(negedge clk);
        check("rst_i2c_rst_n", ifc.i2c_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_config_done", config_done, 0);
        check("rst_config_fail", config_fail, 0);
        check("rst_fail_index", fail_index, 0);
        check("rst_fail_code", fail_code, 0);
        check("rst_register", ifc.i2c_register, 7'h0F);
        check("rst_data", ifc.i2c_data, 9'h000);

`ifdef AUTO_START_EN
        begin
            int c = 0;
            clear_log();
            first_launch = 1'b1;
            rst = 1'b1;
            while (ifc.i2c_rst_n !== 1'b1 && c < 100) begin
                @(negedge clk);
                c++;
            end
            check("auto_start_hold", c, HOLD);
            wait_end("auto_start");
            check_result("auto_start");
        end
`else
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("idle_no_launch", launch_idx.size(), 0);
        check("idle_busy", busy, 0);
`endif

        // Clean run, with a start pulse while busy.
        fill_ok();
        run("normal", 1'b1);
        check("normal_count", launch_idx.size(), 11);
        check("normal_first_reg", launch_reg[0], 7'h0F);
        check("normal_first_data", launch_dat[0], 9'h000);
        check("normal_last_reg", launch_reg[10], 7'h09);
        check("normal_last_data", launch_dat[10], 9'h001);

        // Single fault on index 3, restarted from DONE.
        fill_ok();
        resp[3][0] = 4'h2;
        run("retry_once", 1'b0);
        check("retry_once_count", launch_idx.size(), 12);
        check("retry_once_idx3", count_idx(3), 2);
        check("retry_once_done", config_done, 1);

        // Persistent fault on index 5.
        fill_ok();
        for (int a = 0; a < MAXR; a++) resp[5][a] = 4'h3;
        run("persist_fault", 1'b0);
        check("persist_idx5", count_idx(5), 3);
        check("persist_idx6", count_idx(6), 0);
        check("persist_fail_index", fail_index, 4'd5);
        check("persist_fail_code", fail_code, 4'h3);

        // Controller never answers on index 0.
        fill_ok();
        for (int a = 0; a < MAXR; a++) resp[0][a] = R_HANG;
        run("timeout", 1'b0);
        check("timeout_count", launch_idx.size(), 3);
        check("timeout_fail_index", fail_index, 4'd0);
        check("timeout_fail_code", fail_code, 4'hE);

        // Restart from FAIL.
        fill_ok();
        run("restart_from_fail", 1'b1);

        // Reset during RUN of index 4.
        fill_ok();
        clear_log();
        build_exp();
        first_launch = 1'b1;
        pulse_start();
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 20000 && !hit; c++) begin
                @(negedge clk);
                if (launch_idx.size() == 5 && ifc.i2c_rst_n === 1'b1) hit = 1'b1;
            end
            check("reset_reach_idx4", hit, 1);
        end
        repeat (10) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_i2c_rst_n", ifc.i2c_rst_n, 0);
        check("abort_busy", busy, 0);
        check("abort_config_done", config_done, 0);
        check("abort_config_fail", config_fail, 0);
        check("abort_fail_index", fail_index, 0);
        check("abort_fail_code", fail_code, 0);
        check("abort_register", ifc.i2c_register, 7'h0F);
        check("abort_data", ifc.i2c_data, 9'h000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run("after_reset", 1'b0);
        check("after_reset_first", launch_idx[0], 0);

        // Randomized response tables.
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run("random", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
